// File: rtl/dmem_responder_if.sv
// Load/store request and response bus between the memory stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, holds a
// word-addressed RAM with byte-lane writes, and answers after LATENCY
// cycles with extended load data or an error flag.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  s_bus
);
    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
    localparam logic [2:0]  CNT_INIT = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic        w_accept;
    logic        w_commit;
    logic        w_req_ready;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_unsigned;

    logic [31:0] r_rdata;
    logic        r_error;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic             w_src_we;
    logic [31:0]      w_src_addr;
    logic [31:0]      w_src_wdata;
    logic [1:0]       w_src_size;
    logic             w_src_unsigned;
    logic             w_misalign;
    logic             w_range_err;
    logic             w_err;
    logic [31:0]      w_off;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_be;
    logic [31:0]      w_wrep;
    logic [31:0]      w_rword;

    // Byte lanes touched by an access of the given size at the given low address bits
    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'd0:    return 4'b0001 << lo;
            2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Right-aligned store data copied onto every lane it could land on
    function automatic logic [31:0] store_replicate(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'd0:    return {4{wd[7:0]}};
            2'd1:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Pick the addressed lane(s) out of a RAM word and sign/zero-extend them
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [1:0] lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (sz)
            2'd0:    return uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'd1:    return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    assign w_req_ready = (r_state == S_IDLE) && rst_n;

    // With LATENCY==1 the commit happens on the accept edge itself, so the
    // request fields come straight off the bus while idle.
    assign w_src_we       = (r_state == S_IDLE) ? s_bus.req_we       : r_we;
    assign w_src_addr     = (r_state == S_IDLE) ? s_bus.req_addr     : r_addr;
    assign w_src_wdata    = (r_state == S_IDLE) ? s_bus.req_wdata    : r_wdata;
    assign w_src_size     = (r_state == S_IDLE) ? s_bus.req_size     : r_size;
    assign w_src_unsigned = (r_state == S_IDLE) ? s_bus.req_unsigned : r_unsigned;

    assign w_misalign  = ((w_src_size == 2'd1) && w_src_addr[0]) ||
                         ((w_src_size == 2'd2) && (w_src_addr[1:0] != 2'd0));
    assign w_range_err = ({1'b0, w_src_addr} < {1'b0, BASE_ADDR}) || ({1'b0, w_src_addr} >= LIMIT);
    assign w_err       = (w_src_size == 2'd3) || w_misalign || w_range_err;
    assign w_off       = w_src_addr - BASE_ADDR;
    assign w_idx       = IDX_W'(w_off >> 2);
    assign w_be        = lane_mask(w_src_size, w_src_addr[1:0]);
    assign w_wrep      = store_replicate(w_src_size, w_src_wdata);
    assign w_rword     = r_mem[w_idx];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode plus accept/commit strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (s_bus.req_valid && w_req_ready) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_state_nxt = S_RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = S_RESP;
                    w_commit    = 1'b1;
                end
            end
            S_RESP: begin
                if (s_bus.resp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Wait counter: loaded only on accept, so it can never wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  r_cnt <= 3'd0;
        else if (w_accept)                           r_cnt <= CNT_INIT;
        else if (r_state == S_WAIT && r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
    end

    // Request capture (data path, not reset)
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we       <= s_bus.req_we;
            r_addr     <= s_bus.req_addr;
            r_wdata    <= s_bus.req_wdata;
            r_size     <= s_bus.req_size;
            r_unsigned <= s_bus.req_unsigned;
        end
    end

    // Response registers: filled at commit, cleared when the response is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 32'd0;
            r_error <= 1'b0;
        end else if (w_commit) begin
            r_error <= w_err;
            r_rdata <= (w_err || w_src_we) ? 32'd0
                     : load_extend(w_rword, w_src_size, w_src_addr[1:0], w_src_unsigned);
        end else if (r_state == S_RESP && s_bus.resp_ready) begin
            r_rdata <= 32'd0;
            r_error <= 1'b0;
        end
    end

    // RAM byte-lane write at commit; erroneous stores never touch memory
    always_ff @(posedge clk) begin
        if (w_commit && w_src_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
            end
        end
    end

    assign s_bus.req_ready  = w_req_ready;
    assign s_bus.resp_valid = (r_state == S_RESP);
    assign s_bus.resp_rdata = r_rdata;
    assign s_bus.resp_error = r_error;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases plus random traffic against a
// byte-array memory model.
module tb_dmem_responder;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0;
    localparam int          LAT   = 2;
    localparam int          NB    = 4 * DEPTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [7:0] mb [NB];

    dmem_responder_if bus();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_bus (bus)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: little-endian byte memory, access rules computed directly
    task automatic ref_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [1:0] sz, input bit us,
                              output logic [31:0] ed, output bit ee);
        int      n;
        longint  off;
        longint  v;
        ed = 32'd0;
        ee = (sz == 2'd3);
        n  = 1;
        if (!ee) begin
            n  = 1 << sz;
            ee = ((a % n) != 0) || (longint'(a) < longint'(BASE)) ||
                 (longint'(a) >= longint'(BASE) + longint'(NB));
        end
        if (!ee) begin
            off = longint'(a) - longint'(BASE);
            if (we) begin
                for (int k = 0; k < n; k++) mb[off + k] = 8'(wd >> (8 * k));
            end else begin
                v = 0;
                for (int k = 0; k < n; k++) v = v | (longint'(mb[off + k]) << (8 * k));
                if (!us && v[8 * n - 1]) v = v - (64'sd1 << (8 * n));
                ed = v[31:0];
            end
        end
    endtask

    task automatic txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input bit us, input int stall,
                       output logic [31:0] o_d, output logic o_e);
        logic [31:0] ed;
        bit          ee;
        int          lat;
        logic [31:0] hd;
        logic        he;
        ref_access(we, a, wd, sz, us, ed, ee);
        @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a;
        bus.req_wdata = wd; bus.req_size = sz; bus.req_unsigned = us;
        bus.resp_ready = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.req_we = 1'b1; bus.req_addr = $urandom_range(0, 127);
                bus.req_wdata = $urandom; bus.req_size = 2'd2;
            end
            if (!bus.resp_valid) chk("req_ready_wait", 32'(bus.req_ready), 32'd0);
        end while (!bus.resp_valid && lat < 20);
        chk("latency", 32'(lat), 32'(LAT));
        chk("resp_rdata", bus.resp_rdata, ed);
        chk("resp_error", 32'(bus.resp_error), 32'(ee));
        chk("req_ready_resp", 32'(bus.req_ready), 32'd0);
        hd = bus.resp_rdata;
        he = bus.resp_error;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.resp_valid), 32'd1);
            chk("stall_rdata", bus.resp_rdata, hd);
            chk("stall_error", 32'(bus.resp_error), 32'(he));
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b0;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("done_valid", 32'(bus.resp_valid), 32'd0);
        chk("done_rdata", bus.resp_rdata, 32'd0);
        chk("done_error", 32'(bus.resp_error), 32'd0);
        chk("done_req_ready", 32'(bus.req_ready), 32'd1);
        o_d = hd;
        o_e = he;
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        logic [31:0] ed;
        bit          ee;
        logic [31:0] a;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
        bus.resp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        chk("rst_error", 32'(bus.resp_error), 32'd0);
        rst_n = 1'b1;

        // Preload the working region and the top word
        for (int w = 0; w < 32; w++) txn(1'b1, 32'(4 * w), $urandom, 2'd2, 1'b0, 0, d, e);
        txn(1'b1, 32'hFFC, 32'hA5A5_5A5A, 2'd2, 1'b0, 0, d, e);

        // Word store/load round trip
        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 0, d, e);
        chk("t1_store_err", 32'(e), 32'd0);
        chk("t1_store_rdata", d, 32'd0);
        txn(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 0, d, e);
        chk("t1_load", d, 32'hDEAD_BEEF);

        // Byte lane write and extension
        txn(1'b1, 32'h11, 32'h0000_0080, 2'd0, 1'b0, 0, d, e);
        txn(1'b0, 32'h11, 32'd0, 2'd0, 1'b0, 0, d, e);
        chk("t2_lb_signed", d, 32'hFFFF_FF80);
        txn(1'b0, 32'h11, 32'd0, 2'd0, 1'b1, 0, d, e);
        chk("t2_lb_unsigned", d, 32'h0000_0080);
        txn(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 0, d, e);
        chk("t2_lw", d, 32'hDEAD_80EF);

        // Errors
        txn(1'b0, 32'h13, 32'd0, 2'd1, 1'b0, 0, d, e);
        chk("t3_half_mis_err", 32'(e), 32'd1);
        chk("t3_half_mis_rdata", d, 32'd0);
        txn(1'b1, 32'h12, 32'h1111_2222, 2'd2, 1'b0, 0, d, e);
        chk("t3_word_mis_err", 32'(e), 32'd1);
        txn(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 0, d, e);
        chk("t3_word_unchanged", d, 32'hDEAD_80EF);
        txn(1'b0, 32'h10, 32'd0, 2'd3, 1'b0, 0, d, e);
        chk("t3_size3_err", 32'(e), 32'd1);

        // Range boundary
        txn(1'b0, 32'hFFC, 32'd0, 2'd2, 1'b0, 0, d, e);
        chk("t4_last_word_err", 32'(e), 32'd0);
        chk("t4_last_word_data", d, 32'hA5A5_5A5A);
        txn(1'b0, 32'h1000, 32'd0, 2'd2, 1'b0, 0, d, e);
        chk("t4_past_end_err", 32'(e), 32'd1);

        // Long response stall
        txn(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 10, d, e);
        chk("t5_stall_data", d, 32'hDEAD_80EF);

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6: a = $urandom_range(0, 127);
                7, 8:                a = 32'hFFC + $urandom_range(0, 3);
                default:             a = ($urandom_range(0, 1) != 0) ? 32'h1000 + $urandom_range(0, 7) : $urandom;
            endcase
            txn(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), d, e);
        end

        // Reset while waiting: the store must never land
        ref_access(1'b0, 32'h20, 32'd0, 2'd2, 1'b0, ed, ee);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h20;
        bus.req_wdata = 32'h1234_5678; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("t6_in_wait", 32'(bus.resp_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("t6_rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("t6_rst_rdata", bus.resp_rdata, 32'd0);
        chk("t6_rst_error", 32'(bus.resp_error), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 32'h20, 32'd0, 2'd2, 1'b0, 0, d, e);
        chk("t6_old_value", d, ed);

        // Reset while responding: the committed store persists
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h24;
        bus.req_wdata = 32'hCAFE_F00D; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("t7_in_resp", 32'(bus.resp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", 32'(bus.resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_access(1'b1, 32'h24, 32'hCAFE_F00D, 2'd2, 1'b0, ed, ee);
        txn(1'b0, 32'h24, 32'd0, 2'd2, 1'b0, 0, d, e);
        chk("t7_committed", d, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
